// File: rtl/codec_pkg.sv
// Shared types and constants for the codec/FIR scheduler slice.
package codec_pkg;

    localparam int CODEC_DW = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = 32'hFFFF_FFFF >> (32 - w);
        return (v >= lim) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/codec_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
module codec_sat_cnt
    import codec_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= W'(sat_inc(32'(cnt), W));
    end

endmodule

// File: rtl/codec_fir_sched.sv
// Serialises L/R codec RX samples into one shared FIR and holds results for TX.
// Define CODEC_FIR_SCHED_STATS_EN to build the overrun/underrun event counters.
module codec_fir_sched
    import codec_pkg::*;
#(
    parameter int DW      = CODEC_DW,
    parameter int TIMEOUT = 400,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       rx_vld,
    input  logic [DW-1:0]    rx_data,
    output logic             fir_start,
    output logic             fir_ch,
    output logic [DW-1:0]    fir_din,
    input  logic             fir_dout_vld,
    input  logic [DW-1:0]    fir_dout,
    output logic [DW-1:0]    tx_din0,
    output logic [DW-1:0]    tx_din1,
    output logic [1:0]       tx_din_vld,
    input  logic [1:0]       tx_din_ack,
    input  logic             bypass,
    input  logic             clr_status,
    output logic [1:0]       ovr_flag,
    output logic [1:0]       udf_flag,
    output logic             tmo_flag,
    output logic [CNT_W-1:0] ovr_cnt,
    output logic [CNT_W-1:0] udf_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [1:0]    pend_vld;
    logic [DW-1:0] pend_data [2];
    logic          last_ch;
    logic [TW-1:0] tmo_cnt;

    logic          sel, issue, byp_wr, res_wr, tmo_hit;
    logic [1:0]    drain, tx_wr, ovr_ev, udf_ev;
    logic [DW-1:0] tx_wdata;

    // With both channels pending, serve the one not served last.
    assign sel = pend_vld[1] & (~pend_vld[0] | (last_ch == CH_L));

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        byp_wr   = 1'b0;
        res_wr   = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            IDLE: if (|pend_vld) begin
                if (bypass) byp_wr   = 1'b1;
                else        state_nx = ISSUE;
            end
            ISSUE: begin
                issue    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (fir_dout_vld) begin
                res_wr   = 1'b1;
                state_nx = IDLE;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                tmo_hit  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fir_start = issue;
    assign drain     = issue  ? (fir_ch ? 2'b10 : 2'b01) :
                       byp_wr ? (sel    ? 2'b10 : 2'b01) : 2'b00;
    assign tx_wr     = res_wr ? (fir_ch ? 2'b10 : 2'b01) :
                       byp_wr ? (sel    ? 2'b10 : 2'b01) : 2'b00;
    assign tx_wdata  = res_wr ? fir_dout : pend_data[sel];
    // A sample landing in the cycle its channel drains is a capture, not an overrun.
    assign ovr_ev    = rx_vld & pend_vld & ~drain;
    assign udf_ev    = tx_din_ack & ~tx_din_vld & ~tx_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fir_din <= '0;
            fir_ch  <= CH_L;
            last_ch <= CH_R;
            tmo_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |pend_vld) begin
                last_ch <= sel;
                if (!bypass) begin
                    fir_din <= pend_data[sel];
                    fir_ch  <= sel;
                end
            end
            if (issue)
                tmo_cnt <= '0;
            else if (state == WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld     <= '0;
            pend_data[0] <= '0;
            pend_data[1] <= '0;
        end else begin
            pend_vld <= rx_vld | (pend_vld & ~drain);
            for (int c = 0; c < 2; c++)
                if (rx_vld[c]) pend_data[c] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_din0    <= '0;
            tx_din1    <= '0;
            tx_din_vld <= '0;
        end else begin
            if (tx_wr[0]) tx_din0 <= tx_wdata;
            if (tx_wr[1]) tx_din1 <= tx_wdata;
            tx_din_vld <= tx_wr | (tx_din_vld & ~tx_din_ack);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_status) begin
            ovr_flag <= '0;
            udf_flag <= '0;
            tmo_flag <= 1'b0;
        end else begin
            ovr_flag <= ovr_flag | ovr_ev;
            udf_flag <= udf_flag | udf_ev;
            tmo_flag <= tmo_flag | tmo_hit;
        end
    end

`ifdef CODEC_FIR_SCHED_STATS_EN
    // Both channels erroring in one cycle counts as a single event.
    codec_sat_cnt #(.W(CNT_W)) u_ovr_cnt (
        .clk (clk), .rst (rst), .clr (clr_status), .inc (|ovr_ev), .cnt (ovr_cnt)
    );
    codec_sat_cnt #(.W(CNT_W)) u_udf_cnt (
        .clk (clk), .rst (rst), .clr (clr_status), .inc (|udf_ev), .cnt (udf_cnt)
    );
`else
    assign ovr_cnt = '0;
    assign udf_cnt = '0;
`endif

endmodule

// File: tb/tb_codec_fir_sched.sv
// Bench for codec_fir_sched: spec-level model compared every cycle plus directed literal checks.
module tb_codec_fir_sched;

    localparam int DW      = 24;
    localparam int TIMEOUT = 400;
    localparam int CNT_W   = 16;
`ifdef CODEC_FIR_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       rx_vld;
    logic [DW-1:0]    rx_data;
    logic             fir_start, fir_ch;
    logic [DW-1:0]    fir_din;
    logic             fir_dout_vld;
    logic [DW-1:0]    fir_dout;
    logic [DW-1:0]    tx_din0, tx_din1;
    logic [1:0]       tx_din_vld, tx_din_ack;
    logic             bypass, clr_status;
    logic [1:0]       ovr_flag, udf_flag;
    logic             tmo_flag;
    logic [CNT_W-1:0] ovr_cnt, udf_cnt;

    codec_fir_sched #(.DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data),
        .fir_start(fir_start), .fir_ch(fir_ch), .fir_din(fir_din),
        .fir_dout_vld(fir_dout_vld), .fir_dout(fir_dout),
        .tx_din0(tx_din0), .tx_din1(tx_din1), .tx_din_vld(tx_din_vld),
        .tx_din_ack(tx_din_ack), .bypass(bypass), .clr_status(clr_status),
        .ovr_flag(ovr_flag), .udf_flag(udf_flag), .tmo_flag(tmo_flag),
        .ovr_cnt(ovr_cnt), .udf_cnt(udf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int fir_lat = 10;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // FIR stand-in: result = input + 1 after fir_lat cycles; fir_lat == 0 never answers.
    int            fcnt;
    logic [DW-1:0] fres;
    initial begin
        fir_dout_vld = 1'b0;
        fir_dout     = '0;
        fcnt         = 0;
        fres         = '0;
        forever begin
            @(negedge clk);
            fir_dout_vld = 1'b0;
            if (rst) fcnt = 0;
            else begin
                if (fcnt > 0) begin
                    fcnt--;
                    if (fcnt == 0) begin
                        fir_dout_vld = 1'b1;
                        fir_dout     = fres;
                    end
                end
                if (fir_start && fir_lat > 0) begin
                    fcnt = fir_lat;
                    fres = fir_din + 24'd1;
                end
            end
        end
    end

    // Behavioural model: per-channel mailboxes, a scheduler phase and a wait age.
    int            m_phase;      // 0 idle, 1 launching, 2 waiting for result
    int            m_age;
    int            m_last, m_fch, m_s;
    logic [DW-1:0] m_fdin;
    logic [1:0]    m_pend, m_tvld, m_ovf, m_udf, m_drn, m_wr;
    logic [DW-1:0] m_pdata [2];
    logic [DW-1:0] m_tx [2];
    logic [DW-1:0] m_wdat;
    logic          m_tmo, m_tmo_ev;
    int            m_ovc, m_udc;
    logic          m_oev, m_uev;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_age = 0; m_last = 1; m_fch = 0; m_fdin = '0;
            m_pend = '0; m_tvld = '0; m_ovf = '0; m_udf = '0; m_tmo = 1'b0;
            m_pdata[0] = '0; m_pdata[1] = '0; m_tx[0] = '0; m_tx[1] = '0;
            m_ovc = 0; m_udc = 0;
        end else begin
            m_drn = '0; m_wr = '0; m_wdat = '0; m_tmo_ev = 1'b0;
            m_s = (m_pend == 2'b11) ? 1 - m_last : (m_pend[1] ? 1 : 0);
            if (m_phase == 0) begin
                if (m_pend != 0) begin
                    m_last = m_s;
                    if (bypass) begin
                        m_drn[m_s] = 1'b1; m_wr[m_s] = 1'b1; m_wdat = m_pdata[m_s];
                    end else begin
                        m_fch = m_s; m_fdin = m_pdata[m_s]; m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_drn[m_fch] = 1'b1; m_phase = 2; m_age = 0;
            end else begin
                m_age++;
                if (fir_dout_vld) begin
                    m_wr[m_fch] = 1'b1; m_wdat = fir_dout; m_phase = 0;
                end else if (m_age >= TIMEOUT) begin
                    m_tmo_ev = 1'b1; m_phase = 0;
                end
            end
            m_oev = 1'b0; m_uev = 1'b0;
            for (int c = 0; c < 2; c++) begin
                if (rx_vld[c] && m_pend[c] && !m_drn[c]) begin m_ovf[c] = 1'b1; m_oev = 1'b1; end
                if (rx_vld[c]) begin m_pend[c] = 1'b1; m_pdata[c] = rx_data; end
                else if (m_drn[c]) m_pend[c] = 1'b0;
                if (tx_din_ack[c] && !m_tvld[c] && !m_wr[c]) begin m_udf[c] = 1'b1; m_uev = 1'b1; end
                if (m_wr[c]) begin m_tvld[c] = 1'b1; m_tx[c] = m_wdat; end
                else if (tx_din_ack[c]) m_tvld[c] = 1'b0;
            end
            if (m_tmo_ev) m_tmo = 1'b1;
            if (m_oev && m_ovc < 65535) m_ovc++;
            if (m_uev && m_udc < 65535) m_udc++;
            if (clr_status) begin
                m_ovf = '0; m_udf = '0; m_tmo = 1'b0; m_ovc = 0; m_udc = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fir_start) start_cnt++;
            chk("m_fir_start", 64'(fir_start), 64'(m_phase == 1));
            chk("m_fir_ch",    64'(fir_ch),    64'(m_fch));
            chk("m_fir_din",   64'(fir_din),   64'(m_fdin));
            chk("m_tx_din0",   64'(tx_din0),   64'(m_tx[0]));
            chk("m_tx_din1",   64'(tx_din1),   64'(m_tx[1]));
            chk("m_tx_vld",    64'(tx_din_vld), 64'(m_tvld));
            chk("m_ovr_flag",  64'(ovr_flag),  64'(m_ovf));
            chk("m_udf_flag",  64'(udf_flag),  64'(m_udf));
            chk("m_tmo_flag",  64'(tmo_flag),  64'(m_tmo));
            chk("m_ovr_cnt",   64'(ovr_cnt),   64'(STATS * m_ovc));
            chk("m_udf_cnt",   64'(udf_cnt),   64'(STATS * m_udc));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; rx_vld = '0; rx_data = '0; tx_din_ack = '0;
        bypass = 1'b0; clr_status = 1'b0; fir_lat = 10;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rx_pulse(input logic [1:0] ch, input logic [DW-1:0] d);
        rx_vld = ch; rx_data = d;
        @(negedge clk);
        rx_vld = '0;
    endtask

    task automatic wait_start(input int maxc, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!fir_start && n < maxc);
    endtask

    int n, s0;

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_fir_start", 64'(fir_start), 64'd0);
        chk("rst_tx_vld", 64'(tx_din_vld), 64'd0);
        chk("rst_flags", 64'({ovr_flag, udf_flag, tmo_flag}), 64'd0);
        chk("rst_cnts", 64'({ovr_cnt, udf_cnt}), 64'd0);

        // single left sample through a 10-cycle FIR
        rx_pulse(2'b01, 24'h123456);
        wait_start(20, n);
        chk("t1_start_lat", 64'(n), 64'd1);
        chk("t1_fir_ch", 64'(fir_ch), 64'd0);
        chk("t1_fir_din", 64'(fir_din), 64'h123456);
        n = 0;
        while (!tx_din_vld[0] && n < 50) begin @(negedge clk); n++; end
        chk("t1_res_lat", 64'(n), 64'd11);
        chk("t1_tx_din0", 64'(tx_din0), 64'h123457);
        chk("t1_tx_vld", 64'(tx_din_vld), 64'b01);
        tx_din_ack = 2'b01;
        @(negedge clk);
        tx_din_ack = 2'b00;
        chk("t1_ack_clr", 64'(tx_din_vld), 64'b00);

        // both channels at once
        do_reset();
        fir_lat = 5;
        rx_pulse(2'b11, 24'hABCDEF);
        wait_start(20, n);
        chk("t2_first_ch", 64'(fir_ch), 64'd0);
        wait_start(20, n);
        chk("t2_second_lat", 64'(n), 64'd7);
        chk("t2_second_ch", 64'(fir_ch), 64'd1);
        chk("t2_second_din", 64'(fir_din), 64'hABCDEF);
        n = 0;
        while (tx_din_vld != 2'b11 && n < 50) begin @(negedge clk); n++; end
        chk("t2_tx_din0", 64'(tx_din0), 64'hABCDF0);
        chk("t2_tx_din1", 64'(tx_din1), 64'hABCDF0);
        chk("t2_no_ovr", 64'(ovr_flag), 64'd0);

        // overrun while FIR busy
        do_reset();
        fir_lat = 300;
        rx_pulse(2'b01, 24'h111111);
        wait_start(20, n);
        repeat (20) @(negedge clk);
        rx_pulse(2'b01, 24'h222222);
        repeat (20) @(negedge clk);
        rx_pulse(2'b01, 24'h333333);
        chk("t3_ovr_flag", 64'(ovr_flag), 64'b01);
        chk("t3_ovr_cnt", 64'(ovr_cnt), 64'(STATS));
        wait_start(400, n);
        chk("t3_next_din", 64'(fir_din), 64'h333333);
        chk("t3_tx_din0", 64'(tx_din0), 64'h111112);

        // FIR never answers
        do_reset();
        fir_lat = 0;
        rx_pulse(2'b01, 24'h0A0A0A);
        wait_start(20, n);
        rx_pulse(2'b10, 24'h0B0B0B);
        n = 1;
        while (!tmo_flag && n < 600) begin @(negedge clk); n++; end
        chk("t4_tmo_lat", 64'(n), 64'd401);
        chk("t4_tx_vld", 64'(tx_din_vld), 64'd0);
        fir_lat = 3;
        wait_start(5, n);
        chk("t4_next_lat", 64'(n), 64'd1);
        chk("t4_next_ch", 64'(fir_ch), 64'd1);
        chk("t4_next_din", 64'(fir_din), 64'h0B0B0B);
        n = 0;
        while (!tx_din_vld[1] && n < 20) begin @(negedge clk); n++; end
        chk("t4_tx_din1", 64'(tx_din1), 64'h0B0B0C);

        // underrun then clear
        do_reset();
        tx_din_ack = 2'b10;
        @(negedge clk);
        tx_din_ack = 2'b00;
        chk("t5_udf_flag", 64'(udf_flag), 64'b10);
        chk("t5_udf_cnt", 64'(udf_cnt), 64'(STATS));
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk("t5_clr_flag", 64'(udf_flag), 64'd0);
        chk("t5_clr_cnt", 64'(udf_cnt), 64'd0);

        // bypass path
        do_reset();
        bypass = 1'b1;
        s0 = start_cnt;
        rx_pulse(2'b10, 24'h800000);
        chk("t6_vld_early", 64'(tx_din_vld), 64'd0);
        @(negedge clk);
        chk("t6_tx_din1", 64'(tx_din1), 64'h800000);
        chk("t6_tx_vld", 64'(tx_din_vld), 64'b10);
        repeat (10) @(negedge clk);
        chk("t6_no_start", 64'(start_cnt), 64'(s0));

        // bypass: capture during drain and ack during write
        do_reset();
        bypass = 1'b1;
        rx_vld = 2'b10; rx_data = 24'h00AAAA;
        @(negedge clk);
        rx_vld = 2'b10; rx_data = 24'h00BBBB; tx_din_ack = 2'b10;
        @(negedge clk);
        rx_vld = 2'b00; tx_din_ack = 2'b00;
        chk("t7_tx_din1_a", 64'(tx_din1), 64'h00AAAA);
        chk("t7_vld_kept", 64'(tx_din_vld), 64'b10);
        chk("t7_no_udf", 64'(udf_flag), 64'd0);
        chk("t7_no_ovr", 64'(ovr_flag), 64'd0);
        @(negedge clk);
        chk("t7_tx_din1_b", 64'(tx_din1), 64'h00BBBB);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
